// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared size codes, LSU state enum and alignment mask
package mips_mem_pkg;

  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;
  localparam logic [1:0]  SZ_WORD = 2'b10;
  localparam logic [1:0]  SZ_RSVD = 2'b11;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic {
    IDLE     = 1'b0,
    MERGE_WR = 1'b1
  } lsu_state_t;

endpackage

// File: rtl/lsu_mem_port_if.sv
// rtl/lsu_mem_port_if.sv - word-wide bus between the load/store unit and data Memory
interface lsu_mem_port_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          MemRead;
  logic          MemWrite;
  logic [AW-1:0] Addr;
  logic [DW-1:0] Wd;
  logic [DW-1:0] Rd;

  modport master (output MemRead, output MemWrite, output Addr, output Wd, input Rd);
  modport slave  (input MemRead, input MemWrite, input Addr, input Wd, output Rd);
endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - little-endian lane extract/extend for loads and lane merge for stores
module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rd_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Select the addressed lane and extend it for the load result
  always_comb begin
    case (offset_i)
      2'd0:    lane_b = rd_i[7:0];
      2'd1:    lane_b = rd_i[15:8];
      2'd2:    lane_b = rd_i[23:16];
      default: lane_b = rd_i[31:24];
    endcase
    lane_h = offset_i[1] ? rd_i[31:16] : rd_i[15:0];
    case (size_i)
      SZ_BYTE: load_o = unsigned_i ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_HALF: load_o = unsigned_i ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_o = rd_i;
    endcase
  end

  // Overlay the low byte/half of the store data onto the word just read
  always_comb begin
    merge_o = rd_i;
    if (size_i == SZ_BYTE) begin
      case (offset_i)
        2'd0:    merge_o[7:0]   = wdata_i[7:0];
        2'd1:    merge_o[15:8]  = wdata_i[7:0];
        2'd2:    merge_o[23:16] = wdata_i[7:0];
        default: merge_o[31:24] = wdata_i[7:0];
      endcase
    end else if (size_i == SZ_HALF) begin
      if (offset_i[1]) merge_o[31:16] = wdata_i[15:0];
      else             merge_o[15:0]  = wdata_i[15:0];
    end
  end

endmodule

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - MEM-stage load/store unit with read-modify-write for sub-word stores
module lsu_mem_port
  import mips_mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          Req_Valid,
  input  logic          Req_Read,
  input  logic          Req_Write,
  input  logic [1:0]    Req_Size,
  input  logic          Req_Unsigned,
  input  logic [AW-1:0] Req_Addr,
  input  logic [DW-1:0] Req_Wdata,
  output logic          Stall,
  output logic [DW-1:0] Load_Data,
  output logic          Load_Valid,
  output logic          Mem_Err,
  output logic [AW-1:0] Err_Addr,
  lsu_mem_port_if.master mem
);

  lsu_state_t    state_q, state_d;
  logic [DW-1:0] merge_q, merge_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] err_addr_q, err_addr_d;

  logic [AW-1:0] word_addr;
  logic          req_err;
  logic [DW-1:0] lane_load, lane_merge;

  logic          rd_c, wr_c, stall_c, ldv_c, err_c;
  logic [AW-1:0] addr_c;
  logic [DW-1:0] wd_c, ld_c;

  lsu_lane_align u_align (
    .size_i     (Req_Size),
    .unsigned_i (Req_Unsigned),
    .offset_i   (Req_Addr[1:0]),
    .rd_i       (mem.Rd),
    .wdata_i    (Req_Wdata),
    .load_o     (lane_load),
    .merge_o    (lane_merge)
  );

  // Classify the request: misaligned, reserved size, or both read and write
  always_comb begin
    word_addr = Req_Addr & WORD_ALIGN_MASK[AW-1:0];
    req_err   = Req_Valid &&
                ((Req_Size == SZ_RSVD) ||
                 ((Req_Size == SZ_HALF) && Req_Addr[0]) ||
                 ((Req_Size == SZ_WORD) && (Req_Addr[1:0] != 2'b00)) ||
                 (Req_Read && Req_Write));
  end

  // Next-state and strobe decode; sub-word stores read first, then write the merged word
  always_comb begin
    state_d    = state_q;
    merge_d    = merge_q;
    addr_d     = addr_q;
    err_addr_d = err_addr_q;
    rd_c       = 1'b0;
    wr_c       = 1'b0;
    stall_c    = 1'b0;
    ldv_c      = 1'b0;
    err_c      = 1'b0;
    addr_c     = word_addr;
    wd_c       = '0;
    ld_c       = '0;
    case (state_q)
      IDLE: begin
        if (req_err) begin
          err_c      = 1'b1;
          err_addr_d = Req_Addr;
        end else if (Req_Valid && Req_Read) begin
          rd_c  = 1'b1;
          ldv_c = 1'b1;
          ld_c  = lane_load;
        end else if (Req_Valid && Req_Write) begin
          if (Req_Size == SZ_WORD) begin
            wr_c = 1'b1;
            wd_c = Req_Wdata;
          end else begin
            rd_c    = 1'b1;
            stall_c = 1'b1;
            merge_d = lane_merge;
            addr_d  = word_addr;
            state_d = MERGE_WR;
          end
        end
      end
      default: begin
        wr_c    = 1'b1;
        wd_c    = merge_q;
        addr_c  = addr_q;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are forced low while reset is held, whatever the request inputs do
  always_comb begin
    mem.MemRead  = Rst_n & rd_c;
    mem.MemWrite = Rst_n & wr_c;
    mem.Addr     = Rst_n ? addr_c : '0;
    mem.Wd       = Rst_n ? wd_c : '0;
    Stall        = Rst_n & stall_c;
    Load_Valid   = Rst_n & ldv_c;
    Load_Data    = Rst_n ? ld_c : '0;
    Mem_Err      = Rst_n & err_c;
    Err_Addr     = err_addr_q;
  end

  // State, merge word, held word address and error address registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      merge_q    <= '0;
      addr_q     <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      merge_q    <= merge_d;
      addr_q     <= addr_d;
      err_addr_q <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb/tb_lsu_mem_port.sv - self-checking bench for lsu_mem_port against a byte-level memory model
module tb_lsu_mem_port;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Req_Valid, Req_Read, Req_Write, Req_Unsigned;
  logic [1:0]  Req_Size;
  logic [31:0] Req_Addr, Req_Wdata;
  logic        Stall, Load_Valid, Mem_Err;
  logic [31:0] Load_Data, Err_Addr;

  int n_vec  = 0;
  int n_fail = 0;

  logic [31:0] mem  [64];
  logic [7:0]  rmem [256];

  lsu_mem_port_if #(.AW(32), .DW(32)) mif ();

  lsu_mem_port #(.AW(32), .DW(32)) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Req_Valid    (Req_Valid),
    .Req_Read     (Req_Read),
    .Req_Write    (Req_Write),
    .Req_Size     (Req_Size),
    .Req_Unsigned (Req_Unsigned),
    .Req_Addr     (Req_Addr),
    .Req_Wdata    (Req_Wdata),
    .Stall        (Stall),
    .Load_Data    (Load_Data),
    .Load_Valid   (Load_Valid),
    .Mem_Err      (Mem_Err),
    .Err_Addr     (Err_Addr),
    .mem          (mif)
  );

  always #5 Clk = ~Clk;

  assign mif.Rd = mem[mif.Addr[7:2]];

  always @(posedge Clk) begin
    if (mif.MemWrite) mem[mif.Addr[7:2]] = mif.Wd;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rmem[8'(a[7:2] * 4 + i)];
    return w;
  endfunction

  task automatic apply(input logic v, input logic r, input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] a, input logic [31:0] wd);
    int          nb;
    logic        err;
    logic [31:0] wa, val;
    Req_Valid = v; Req_Read = r; Req_Write = w; Req_Size = sz;
    Req_Unsigned = u; Req_Addr = a; Req_Wdata = wd;
    nb  = 1 << sz;
    wa  = {a[31:2], 2'b00};
    err = v && ((r && w) || (sz == 2'd3) || ((a % nb) != 0));
    val = 32'h0;
    if (!err && nb <= 4) begin
      for (int i = 0; i < nb; i++) val = val | (32'(rmem[8'(a + i)]) << (8 * i));
      if (!u && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8 * nb));
    end
    @(negedge Clk);
    chk("mem_err", {31'h0, Mem_Err}, {31'h0, err});
    if (!v) begin
      chk("idle_rd", {30'h0, mif.MemRead, mif.MemWrite}, 32'h0);
      chk("idle_ld", Load_Data, 32'h0);
      chk("idle_ldv", {31'h0, Load_Valid}, 32'h0);
    end else if (err) begin
      chk("err_strb", {29'h0, mif.MemRead, mif.MemWrite, Load_Valid}, 32'h0);
      @(posedge Clk); #1;
      chk("err_addr", Err_Addr, a);
    end else if (r) begin
      chk("ld_strb", {29'h0, mif.MemRead, mif.MemWrite, Stall}, 32'h4);
      chk("ld_valid", {31'h0, Load_Valid}, 32'h1);
      chk("ld_data", Load_Data, val);
      chk("ld_addr", mif.Addr, wa);
    end else if (w) begin
      for (int i = 0; i < nb; i++) rmem[8'(a + i)] = wd[8*i +: 8];
      if (nb == 4) begin
        chk("sw_strb", {29'h0, mif.MemRead, mif.MemWrite, Stall}, 32'h2);
        chk("sw_wd", mif.Wd, wd);
        chk("sw_addr", mif.Addr, wa);
      end else begin
        chk("rmw_c1", {29'h0, mif.MemRead, mif.MemWrite, Stall}, 32'h5);
        chk("rmw_c1_addr", mif.Addr, wa);
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("rmw_c2", {29'h0, mif.MemRead, mif.MemWrite, Stall}, 32'h2);
        chk("rmw_wd", mif.Wd, ref_word(wa));
        chk("rmw_addr", mif.Addr, wa);
      end
    end else begin
      chk("nop_strb", {30'h0, mif.MemRead, mif.MemWrite}, 32'h0);
    end
    @(posedge Clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    for (int i = 0; i < 256; i++) rmem[i] = 8'h0;
    Req_Valid = 1'b1; Req_Read = 1'b1; Req_Write = 1'b0; Req_Size = 2'd0;
    Req_Unsigned = 1'b0; Req_Addr = 32'd89; Req_Wdata = 32'hFFFF_FFFF;

    #3;
    chk("rst_strb", {27'h0, mif.MemRead, mif.MemWrite, Stall, Load_Valid, Mem_Err}, 32'h0);
    chk("rst_ld", Load_Data, 32'h0);
    chk("rst_addr", mif.Addr, 32'h0);
    chk("rst_erraddr", Err_Addr, 32'h0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;

    apply(1, 0, 1, 2'd2, 0, 32'd88, 32'h1234_5678);
    chk("mem88_word", mem[22], 32'h1234_5678);
    apply(1, 0, 1, 2'd0, 0, 32'd89, 32'h0000_00AB);
    chk("mem88_byte", mem[22], 32'h1234_AB78);
    apply(1, 1, 0, 2'd0, 0, 32'd89, 32'h0);
    chk("lb89", Load_Data, 32'hFFFF_FFAB);
    apply(1, 1, 0, 2'd0, 1, 32'd89, 32'h0);
    apply(1, 1, 0, 2'd1, 0, 32'd90, 32'h0);
    apply(1, 1, 0, 2'd2, 0, 32'd88, 32'h0);
    apply(1, 1, 0, 2'd2, 0, 32'd90, 32'h0);
    chk("erraddr90", Err_Addr, 32'd90);
    apply(1, 1, 1, 2'd2, 0, 32'd88, 32'hDEAD_BEEF);
    chk("rw_nochange", mem[22], 32'h1234_AB78);
    apply(0, 1, 1, 2'd3, 0, 32'd91, 32'h0);
    apply(1, 0, 1, 2'd0, 0, 32'd88, 32'h0000_0011);
    apply(1, 0, 1, 2'd1, 0, 32'd90, 32'h0000_8001);
    apply(1, 1, 0, 2'd1, 0, 32'd90, 32'h0);
    apply(1, 1, 0, 2'd2, 0, 32'd88, 32'h0);
    chk("b2b_merge", mem[22], 32'h8001_AB11);

    Req_Valid = 1'b1; Req_Read = 1'b0; Req_Write = 1'b1; Req_Size = 2'd1;
    Req_Unsigned = 1'b0; Req_Addr = 32'd88; Req_Wdata = 32'h0000_BEEF;
    @(negedge Clk);
    chk("rstm_c1", {30'h0, mif.MemRead, Stall}, 32'h3);
    @(posedge Clk); #2;
    Rst_n = 1'b0;
    #1;
    chk("rstm_out", {28'h0, mif.MemRead, mif.MemWrite, Stall, Mem_Err}, 32'h0);
    chk("rstm_wd", mif.Wd, 32'h0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    Req_Valid = 1'b0;
    @(negedge Clk);
    chk("rstm_idle", {30'h0, mif.MemWrite, Stall}, 32'h0);
    chk("rstm_mem", mem[22], 32'h8001_AB11);
    @(posedge Clk); #1;
    apply(1, 1, 0, 2'd2, 0, 32'd88, 32'h0);

    for (int n = 0; n < 80; n++) begin
      logic       v, r, w;
      logic [1:0] op;
      v  = ($urandom_range(0, 9) != 0);
      op = 2'($urandom_range(0, 3));
      r  = (op == 2'd0) || (op == 2'd2);
      w  = (op == 2'd1) || (op == 2'd2);
      apply(v, r, w, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'(64 + $urandom_range(0, 63)), $urandom);
    end

    for (int i = 16; i < 32; i++) chk("final_mem", mem[i], ref_word(32'(i * 4)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
